// File: rtl/csr_machine_file_pkg.sv
// ---------------------------------------------------------------------------
// csr_machine_file_pkg
// Shared definitions for the machine-mode CSR file: 12-bit CSR addresses,
// the CSR operation encoding, mstatus bit positions, interrupt cause codes
// (which double as the mip/mie bit positions) and fixed read values.
// ---------------------------------------------------------------------------
package csr_machine_file_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    // Setting this address bit selects the high half of a counter (0xB8x).
    localparam logic [11:0] CSR_COUNTER_HI_BIT = 12'h080;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csrOp_e;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Interrupt cause codes; also the bit positions inside mip and mie
    localparam logic [4:0] IRQ_CAUSE_SOFTWARE = 5'd3;
    localparam logic [4:0] IRQ_CAUSE_TIMER    = 5'd7;
    localparam logic [4:0] IRQ_CAUSE_EXTERNAL = 5'd11;

    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK    = 32'h0000_0888;
    localparam logic [31:0] MCAUSE_MASK = 32'h8000_001F;

    // Writable bits of mcountinhibit: CY (0), IR (2) and one bit per HPM counter.
    function automatic logic [31:0] count_inhibit_mask(input int num_hpm);
        logic [31:0] mask;
        mask = 32'h0000_0005;
        for (int i = 0; i < num_hpm; i++) begin
            mask[3 + i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// ---------------------------------------------------------------------------
// csr_counter
// One WIDTH-bit machine counter (mcycle, minstret or an mhpmcounter).
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   increment        count strobe for this cycle
//   inhibit          mcountinhibit bit; blocks the increment when 1
//   writeLow         replace count[31:0] with data
//   writeHigh        replace count[WIDTH-1:32] with data[WIDTH-33:0]
//   data             write data
//   count            full counter value
// A write to either half takes precedence over (and suppresses) the
// increment of the same cycle. The count wraps naturally at 2^WIDTH.
// ---------------------------------------------------------------------------
module csr_counter
    import csr_machine_file_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    input  logic             inhibit,
    input  logic             writeLow,
    input  logic             writeHigh,
    input  logic [31:0]      data,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (writeLow) begin
            r_count[31:0] <= data;
        end else if (writeHigh) begin
            r_count[WIDTH-1:32] <= data[WIDTH-33:0];
        end else if (increment && !inhibit) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/csr_machine_file.sv
// ---------------------------------------------------------------------------
// csr_machine_file
// Machine-mode CSR file: full 12-bit address decode, write/set/clear
// operations, cycle/instret/HPM counters with inhibit, registered mip,
// trap entry and mret handling, and illegal-access detection.
// Ports:
//   clock, reset                       clock, asynchronous active-low reset
//   csrAddress/csrOp/csrWriteData      CSR access (op: none/write/set/clear)
//   csrReadData, csrIllegal            combinational read value and legality
//   retire, hpmEvent                   counter strobes
//   externalIrq/timerIrq/softwareIrq   interrupt lines, sampled into mip
//   trapTake/trapInterrupt/trapCause/trapPC/trapValue   trap entry
//   mretSignal                         return from trap
//   trapVector, mepcOut, irqPending    handler target, mret target, pending irq
// Update priority per cycle: trapTake > mretSignal > CSR write. A trap drops
// the same-cycle CSR write completely; mret only wins over a write to mstatus.
// Counters keep counting regardless of traps.
// ---------------------------------------------------------------------------
module csr_machine_file
    import csr_machine_file_pkg::*;
#(
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_HPM       = 4,
    parameter bit VECTORED      = 1'b1,
    parameter int HART_ID       = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [11:0]        csrAddress,
    input  logic [1:0]         csrOp,
    input  logic [31:0]        csrWriteData,
    output logic [31:0]        csrReadData,
    output logic               csrIllegal,
    input  logic               retire,
    input  logic [NUM_HPM-1:0] hpmEvent,
    input  logic               externalIrq,
    input  logic               timerIrq,
    input  logic               softwareIrq,
    input  logic               trapTake,
    input  logic               trapInterrupt,
    input  logic [4:0]         trapCause,
    input  logic [31:0]        trapPC,
    input  logic [31:0]        trapValue,
    input  logic               mretSignal,
    output logic [31:0]        trapVector,
    output logic [31:0]        mepcOut,
    output logic               irqPending
);

    localparam int          NUM_COUNTERS = 2 + NUM_HPM;
    localparam logic [31:0] INHIBIT_MASK = count_inhibit_mask(NUM_HPM);
    // mtvec MODE is limited to 0/1; MODE=1 only when vectoring is built in.
    localparam logic [31:0] MTVEC_MASK   = VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

    // Architectural state
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mip;
    logic [31:0] r_mcountinhibit;

    csrOp_e                   w_op;
    logic [31:0]              w_rdata;
    logic                     w_implemented;
    logic                     w_is_id;
    logic                     w_illegal;
    logic [31:0]              w_new;
    logic                     w_csr_we;
    logic [31:0]              w_mip_next;
    logic [31:0]              w_mtvec_base;
    logic [NUM_COUNTERS-1:0]  w_counter_sel;
    logic [COUNTER_WIDTH-1:0] w_count [NUM_COUNTERS];

    assign w_op = csrOp_e'(csrOp);

    // Address decode and read mux. Counter index 0 is mcycle, 1 is minstret,
    // 2+i is mhpmcounter(3+i); the high-half bit is masked off for matching.
    always_comb begin
        logic [11:0] v_target;
        w_rdata       = '0;
        w_implemented = 1'b1;
        w_is_id       = 1'b0;
        w_counter_sel = '0;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (k == 0)      v_target = CSR_MCYCLE;
            else if (k == 1) v_target = CSR_MINSTRET;
            else             v_target = CSR_MHPMCOUNTER3 + 12'(k - 2);
            if ((csrAddress & ~CSR_COUNTER_HI_BIT) == v_target) begin
                w_counter_sel[k] = 1'b1;
            end
        end
        if (|w_counter_sel) begin
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                if (w_counter_sel[k]) begin
                    w_rdata = csrAddress[7] ? 32'(w_count[k] >> 32) : w_count[k][31:0];
                end
            end
        end else begin
            unique case (csrAddress)
                CSR_MSTATUS: begin
                    w_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                    w_rdata[MSTATUS_MPIE]                  = r_mstatus_mpie;
                    w_rdata[MSTATUS_MIE]                   = r_mstatus_mie;
                end
                CSR_MISA:          w_rdata = MISA_VALUE;
                CSR_MIE:           w_rdata = r_mie;
                CSR_MTVEC:         w_rdata = r_mtvec;
                CSR_MCOUNTINHIBIT: w_rdata = r_mcountinhibit;
                CSR_MSCRATCH:      w_rdata = r_mscratch;
                CSR_MEPC:          w_rdata = r_mepc;
                CSR_MCAUSE:        w_rdata = r_mcause;
                CSR_MTVAL:         w_rdata = r_mtval;
                CSR_MIP:           w_rdata = r_mip;
                CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: begin
                    w_is_id = 1'b1;
                end
                CSR_MHARTID: begin
                    w_is_id = 1'b1;
                    w_rdata = 32'(HART_ID);
                end
                default: w_implemented = 1'b0;
            endcase
        end
    end

    // Read-only IDs tolerate set/clear only with a zero mask (csrrs rd, x0 style).
    assign w_illegal = ((w_op != CSR_OP_NONE) && !w_implemented)
                     || (w_is_id && (w_op == CSR_OP_WRITE))
                     || (w_is_id && ((w_op == CSR_OP_SET) || (w_op == CSR_OP_CLEAR))
                         && (csrWriteData != 32'h0));

    always_comb begin
        unique case (w_op)
            CSR_OP_WRITE: w_new = csrWriteData;
            CSR_OP_SET:   w_new = w_rdata | csrWriteData;
            CSR_OP_CLEAR: w_new = w_rdata & ~csrWriteData;
            default:      w_new = w_rdata;
        endcase
    end

    assign w_csr_we = (w_op != CSR_OP_NONE) && !w_illegal && !trapTake;

    always_comb begin
        w_mip_next                     = '0;
        w_mip_next[IRQ_CAUSE_SOFTWARE] = softwareIrq;
        w_mip_next[IRQ_CAUSE_TIMER]    = timerIrq;
        w_mip_next[IRQ_CAUSE_EXTERNAL] = externalIrq;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mstatus_mie   <= 1'b0;
            r_mstatus_mpie  <= 1'b0;
            r_mie           <= '0;
            r_mtvec         <= '0;
            r_mscratch      <= '0;
            r_mepc          <= '0;
            r_mcause        <= '0;
            r_mtval         <= '0;
            r_mip           <= '0;
            r_mcountinhibit <= '0;
        end else begin
            r_mip <= w_mip_next;
            if (w_csr_we) begin
                unique case (csrAddress)
                    CSR_MSTATUS: begin
                        if (!mretSignal) begin
                            r_mstatus_mie  <= w_new[MSTATUS_MIE];
                            r_mstatus_mpie <= w_new[MSTATUS_MPIE];
                        end
                    end
                    CSR_MIE:           r_mie           <= w_new & MIE_MASK;
                    CSR_MTVEC:         r_mtvec         <= w_new & MTVEC_MASK;
                    CSR_MCOUNTINHIBIT: r_mcountinhibit <= w_new & INHIBIT_MASK;
                    CSR_MSCRATCH:      r_mscratch      <= w_new;
                    CSR_MEPC:          r_mepc          <= {w_new[31:2], 2'b00};
                    CSR_MCAUSE:        r_mcause        <= w_new & MCAUSE_MASK;
                    CSR_MTVAL:         r_mtval         <= w_new;
                    default: ;
                endcase
            end
            if (trapTake) begin
                r_mepc         <= {trapPC[31:2], 2'b00};
                r_mcause       <= {trapInterrupt, 26'b0, trapCause};
                r_mtval        <= trapValue;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mretSignal) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_counter
        // Inhibit bit is CY=0, IR=2, HPM=3+i, i.e. the counter's CSR offset.
        localparam int INH_BIT = (g == 0) ? 0 : g + 1;
        logic w_strobe;
        if (g == 0) begin : g_cycle
            assign w_strobe = 1'b1;
        end else if (g == 1) begin : g_instret
            assign w_strobe = retire;
        end else begin : g_hpm
            assign w_strobe = hpmEvent[g-2];
        end
        csr_counter #(
            .WIDTH(COUNTER_WIDTH)
        ) u_counter (
            .clock    (clock),
            .reset    (reset),
            .increment(w_strobe),
            .inhibit  (r_mcountinhibit[INH_BIT]),
            .writeLow (w_csr_we && w_counter_sel[g] && !csrAddress[7]),
            .writeHigh(w_csr_we && w_counter_sel[g] && csrAddress[7]),
            .data     (w_new),
            .count    (w_count[g])
        );
    end

    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
    assign trapVector   = (r_mtvec[0] && trapInterrupt)
                        ? w_mtvec_base + {25'b0, trapCause, 2'b00}
                        : w_mtvec_base;

    assign csrReadData = w_rdata;
    assign csrIllegal  = w_illegal;
    assign mepcOut     = r_mepc;
    assign irqPending  = r_mstatus_mie & (|(r_mie & r_mip));

endmodule

// File: tb/tb_csr_machine_file.sv
module tb_csr_machine_file;

    localparam int HART = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] csrAddress = '0;
    logic [1:0]  csrOp = '0;
    logic [31:0] csrWriteData = '0;
    logic [31:0] csrReadData;
    logic        csrIllegal;
    logic        retire = 1'b0;
    logic [3:0]  hpmEvent = '0;
    logic        externalIrq = 1'b0;
    logic        timerIrq = 1'b0;
    logic        softwareIrq = 1'b0;
    logic        trapTake = 1'b0;
    logic        trapInterrupt = 1'b0;
    logic [4:0]  trapCause = '0;
    logic [31:0] trapPC = '0;
    logic [31:0] trapValue = '0;
    logic        mretSignal = 1'b0;
    logic [31:0] trapVector;
    logic [31:0] mepcOut;
    logic        irqPending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    csr_machine_file #(
        .COUNTER_WIDTH(64),
        .NUM_HPM(4),
        .VECTORED(1'b1),
        .HART_ID(HART)
    ) dut (
        .clock(clock), .reset(reset),
        .csrAddress(csrAddress), .csrOp(csrOp), .csrWriteData(csrWriteData),
        .csrReadData(csrReadData), .csrIllegal(csrIllegal),
        .retire(retire), .hpmEvent(hpmEvent),
        .externalIrq(externalIrq), .timerIrq(timerIrq), .softwareIrq(softwareIrq),
        .trapTake(trapTake), .trapInterrupt(trapInterrupt), .trapCause(trapCause),
        .trapPC(trapPC), .trapValue(trapValue), .mretSignal(mretSignal),
        .trapVector(trapVector), .mepcOut(mepcOut), .irqPending(irqPending)
    );

    // ---------------- reference model (architectural view) ----------------
    logic        m_mie_b, m_mpie_b;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip, m_inh;
    logic [63:0] m_cnt [6];
    // CSR offset of each counter; also its mcountinhibit bit
    int          cnt_csr [6] = '{0, 2, 3, 4, 5, 6};

    function automatic void m_reset();
        m_mie_b = 0; m_mpie_b = 0;
        m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_mip = 0; m_inh = 0;
        for (int k = 0; k < 6; k++) m_cnt[k] = 0;
    endfunction

    function automatic int m_cnt_hit(input logic [11:0] a, output bit hi);
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            if (a == 12'hB00 + 12'(cnt_csr[k])) return k;
            if (a == 12'hB80 + 12'(cnt_csr[k])) begin hi = 1; return k; end
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        bit hi;
        int k;
        k = m_cnt_hit(a, hi);
        if (k >= 0) return hi ? m_cnt[k][63:32] : m_cnt[k][31:0];
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie_b) << 7) | (32'(m_mie_b) << 3);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h320: return m_inh;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hF14: return 32'(HART);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_is_id(input logic [11:0] a);
        return (a >= 12'hF11) && (a <= 12'hF14);
    endfunction

    function automatic bit m_impl(input logic [11:0] a);
        bit hi;
        if (m_cnt_hit(a, hi) >= 0) return 1;
        return (a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340,
                          12'h341, 12'h342, 12'h343, 12'h344}) || m_is_id(a);
    endfunction

    function automatic bit m_illegal(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        return (op != 0 && !m_impl(a)) || (m_is_id(a) && op == 2'b01)
            || (m_is_id(a) && op >= 2'b10 && d != 0);
    endfunction

    function automatic logic [31:0] m_vector();
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[0] && trapInterrupt) return base + 32'(trapCause) * 4;
        return base;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    function automatic void model_step();
        logic [31:0] old, nv;
        bit          ill, we, hi, strobe;
        int          k;
        if (!reset) begin m_reset(); return; end
        old = m_read(csrAddress);
        ill = m_illegal(csrAddress, csrOp, csrWriteData);
        case (csrOp)
            2'b01:   nv = csrWriteData;
            2'b10:   nv = old | csrWriteData;
            2'b11:   nv = old & ~csrWriteData;
            default: nv = old;
        endcase
        we = (csrOp != 0) && !ill && !trapTake;
        k = m_cnt_hit(csrAddress, hi);
        for (int j = 0; j < 6; j++) begin
            strobe = (j == 0) ? 1'b1 : (j == 1) ? retire : hpmEvent[j-2];
            if (we && j == k) begin
                if (hi) m_cnt[j][63:32] = nv;
                else    m_cnt[j][31:0]  = nv;
            end else if (strobe && !m_inh[cnt_csr[j]]) begin
                m_cnt[j] = m_cnt[j] + 1;
            end
        end
        if (we) begin
            case (csrAddress)
                12'h300: if (!mretSignal) begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
                12'h304: m_mie = nv & 32'h888;
                12'h305: m_mtvec = nv & 32'hFFFF_FFFD;
                12'h320: m_inh = nv & 32'h7D;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv & 32'h8000_001F;
                12'h343: m_mtval = nv;
                default: ;
            endcase
        end
        if (trapTake) begin
            m_mepc   = trapPC & ~32'h3;
            m_mcause = {trapInterrupt, 26'b0, trapCause};
            m_mtval  = trapValue;
            m_mpie_b = m_mie_b;
            m_mie_b  = 0;
        end else if (mretSignal) begin
            m_mie_b  = m_mpie_b;
            m_mpie_b = 1;
        end
        m_mip = (32'(externalIrq) << 11) | (32'(timerIrq) << 7) | (32'(softwareIrq) << 3);
    endfunction

    // ---------------- driver tasks and checker ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csrAddress = a; csrOp = op; csrWriteData = d;
        #1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        csrOp = 2'b00; trapTake = 0; mretSignal = 0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(12'h000, 2'b00, 0);
            cycle();
        end
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [13];

    logic [11:0] addr_list [24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340,
                                    12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02,
                                    12'hB03, 12'hB06, 12'hB80, 12'hB82, 12'hB83, 12'hB86,
                                    12'hB01, 12'hB07, 12'hF11, 12'hF14, 12'h7C0, 12'h000};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        m_reset();

        vecs[0]  = '{12'h300, 2'b00, 32'h0,        32'h0000_1800, 1'b0};
        vecs[1]  = '{12'h301, 2'b00, 32'h0,        32'h4000_0100, 1'b0};
        vecs[2]  = '{12'h301, 2'b01, 32'hFFFF_FFFF, 32'h4000_0100, 1'b0};
        vecs[3]  = '{12'h7C0, 2'b10, 32'h1,        32'h0,         1'b1};
        vecs[4]  = '{12'h7C0, 2'b00, 32'h0,        32'h0,         1'b0};
        vecs[5]  = '{12'hF14, 2'b10, 32'h0,        32'(HART),     1'b0};
        vecs[6]  = '{12'hF14, 2'b01, 32'h5,        32'(HART),     1'b1};
        vecs[7]  = '{12'hF11, 2'b11, 32'h1,        32'h0,         1'b1};
        vecs[8]  = '{12'hF12, 2'b00, 32'h0,        32'h0,         1'b0};
        vecs[9]  = '{12'h305, 2'b00, 32'h0,        32'h0,         1'b0};
        vecs[10] = '{12'h344, 2'b01, 32'hFFF,      32'h0,         1'b0};
        vecs[11] = '{12'hB01, 2'b01, 32'h1,        32'h0,         1'b1};
        vecs[12] = '{12'hB07, 2'b01, 32'h1,        32'h0,         1'b1};

        // reset state
        #1;
        check("rst_mepcOut", mepcOut, 0);
        check("rst_trapVector", trapVector, 0);
        check("rst_irqPending", 32'(irqPending), 0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        cycle();
        cycle();

        drive(12'hB00, 2'b00, 0);
        got = csrReadData;
        check("mcycle_model", got, m_cnt[0][31:0]);
        n_checks++;
        if (!(got > 0 && got < 64)) begin
            n_errors++;
            $display("FAIL mcycle_small got=%h exp=1..63", got);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].op, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), csrReadData, vecs[i].exp_rdata);
            check($sformatf("vec%0d_illegal", i), 32'(csrIllegal), 32'(vecs[i].exp_ill));
            cycle();
        end

        // mscratch write/set/clear
        drive(12'h340, 2'b01, 32'hDEAD_BEEF); cycle();
        drive(12'h340, 2'b00, 0);
        check("mscratch_write", csrReadData, 32'hDEAD_BEEF);
        drive(12'h340, 2'b10, 32'h0000_00F0); cycle();
        drive(12'h340, 2'b11, 32'h0000_000F); cycle();
        drive(12'h340, 2'b00, 0);
        check("mscratch_setclr", csrReadData, 32'hDEAD_BEF0);

        // mcycle carry into the high half, then inhibit
        drive(12'hB00, 2'b01, 32'hFFFF_FFFE); cycle();
        drive(12'hB80, 2'b01, 32'h0); cycle();
        idle(3);
        drive(12'hB00, 2'b00, 0);
        check("mcycle_lo_carry", csrReadData, 32'h1);
        drive(12'hB80, 2'b00, 0);
        check("mcycle_hi_carry", csrReadData, 32'h1);
        drive(12'h320, 2'b10, 32'h1); cycle();
        drive(12'hB00, 2'b00, 0);
        check("mcycle_inhibit_a", csrReadData, 32'h2);
        idle(3);
        drive(12'hB00, 2'b00, 0);
        check("mcycle_inhibit_b", csrReadData, 32'h2);

        // interrupt pending, vectored trap entry, mret
        drive(12'h300, 2'b10, 32'h8); cycle();
        drive(12'h304, 2'b01, 32'h80); cycle();
        timerIrq = 1;
        drive(12'h000, 2'b00, 0);
        check("irq_latency_0", 32'(irqPending), 0);
        cycle();
        check("irq_latency_1", 32'(irqPending), 1);
        drive(12'h305, 2'b01, 32'h1001); cycle();
        trapCause = 5'd7; trapPC = 32'h400; trapValue = 32'h0; trapInterrupt = 0;
        #1;
        check("vector_exception", trapVector, 32'h1000);
        trapInterrupt = 1; trapTake = 1;
        drive(12'h000, 2'b00, 0);
        check("vector_interrupt", trapVector, 32'h101C);
        cycle();
        timerIrq = 0;
        drive(12'h342, 2'b00, 0);
        check("trap_mcause", csrReadData, 32'h8000_0007);
        drive(12'h300, 2'b00, 0);
        check("trap_mstatus", csrReadData, 32'h0000_1880);
        check("trap_irq_masked", 32'(irqPending), 0);
        mretSignal = 1;
        drive(12'h000, 2'b00, 0);
        cycle();
        drive(12'h300, 2'b00, 0);
        check("mret_mstatus", csrReadData, 32'h0000_1888);

        // trap beats a same-cycle mepc write
        trapTake = 1; trapPC = 32'h2003; trapInterrupt = 0; trapCause = 5'd2;
        drive(12'h341, 2'b01, 32'h1234);
        cycle();
        check("trap_mepcOut", mepcOut, 32'h2000);
        drive(12'h341, 2'b00, 0);
        check("trap_mepc_read", csrReadData, 32'h2000);

        // randomized traffic against the model
        drive(12'h320, 2'b01, 32'h0); cycle();
        for (int n = 0; n < 300; n++) begin
            retire = 1'($urandom_range(0, 1));
            hpmEvent = 4'($urandom);
            externalIrq = 1'($urandom_range(0, 1));
            timerIrq = 1'($urandom_range(0, 1));
            softwareIrq = 1'($urandom_range(0, 1));
            trapInterrupt = 1'($urandom_range(0, 1));
            trapCause = 5'($urandom);
            trapPC = $urandom;
            trapValue = $urandom;
            trapTake = ($urandom_range(0, 15) == 0);
            mretSignal = !trapTake && ($urandom_range(0, 15) == 0);
            drive(addr_list[$urandom_range(0, 23)], 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            check("rnd_rdata", csrReadData, m_read(csrAddress));
            check("rnd_illegal", 32'(csrIllegal), 32'(m_illegal(csrAddress, csrOp, csrWriteData)));
            check("rnd_trapVector", trapVector, m_vector());
            check("rnd_mepcOut", mepcOut, m_mepc);
            check("rnd_irqPending", 32'(irqPending),
                  32'(m_mie_b & (|(m_mie & m_mip))));
            cycle();
        end

        // asynchronous reset in the middle of operation
        externalIrq = 0; timerIrq = 0; softwareIrq = 0; retire = 0; hpmEvent = 0;
        trapInterrupt = 0;
        reset = 1'b0;
        drive(12'h340, 2'b00, 0);
        check("midrst_mscratch", csrReadData, 0);
        check("midrst_mepcOut", mepcOut, 0);
        check("midrst_trapVector", trapVector, 0);
        check("midrst_irqPending", 32'(irqPending), 0);
        drive(12'h300, 2'b00, 0);
        check("midrst_mstatus", csrReadData, 32'h0000_1800);
        m_reset();
        cycle();
        cycle();
        reset = 1'b1;
        drive(12'hB00, 2'b00, 0);
        check("midrst_mcycle0", csrReadData, 0);
        cycle();
        drive(12'hB00, 2'b00, 0);
        check("midrst_mcycle1", csrReadData, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
